// File: rtl/int_seq.sv
// Interrupt/BRK/reset entry sequencer for the 6502 core: arbitrates entries at
// instruction boundaries, then owns the bus for six cycles to push PC/P and load the vector.
module int_seq #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        READY,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        sync,
    input  logic        brk_start,
    input  logic        i_flag,
    input  logic [15:0] pc,
    input  logic [7:0]  p,
    input  logic [7:0]  sp,
    input  logic [7:0]  din,
    output logic        busy,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        rw,
    output logic        sp_dec,
    output logic        set_i,
    output logic        pc_load,
    output logic [15:0] pc_new,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6
    } state_t;

    typedef enum logic [1:0] {
        K_RST, K_NMI, K_IRQ, K_BRK
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic        nmi_lat_q, nmi_lat_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        first_q, first_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic [15:0] vec_addr;
    logic        push_rd;
    logic        push_go;

    always_comb begin
        case (kind_q)
            K_NMI:   vec_addr = NMI_VEC;
            K_RST:   vec_addr = RST_VEC;
            default: vec_addr = IRQ_VEC;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        vec_lo_d   = vec_lo_q;
        nmi_prev_d = NMI;
        first_d    = 1'b0;
        // The first cycle after reset is masked so an NMI held low across reset is not an edge.
        nmi_lat_d  = nmi_lat_q | (nmi_prev_q & ~NMI & ~first_q);
        addr       = '0;
        dout       = '0;
        rw         = 1'b1;
        sp_dec     = 1'b0;
        set_i      = 1'b0;
        pc_load    = 1'b0;
        pc_new     = '0;
        done       = 1'b0;
        push_rd    = (kind_q == K_RST);
        push_go    = ~push_rd | READY;

        case (state_q)
            ST_IDLE: begin
                if (sync && READY && nmi_lat_q) begin
                    kind_d  = K_NMI;
                    state_d = ST_S1;
                end else if (sync && READY && !IRQ && !i_flag) begin
                    kind_d  = K_IRQ;
                    state_d = ST_S1;
                end else if (brk_start) begin
                    kind_d  = K_BRK;
                    state_d = ST_S1;
                end
            end
            ST_S1: begin
                addr = pc;
                if (READY) state_d = ST_S2;
            end
            ST_S2: begin
                addr   = {8'h01, sp};
                dout   = pc[15:8];
                rw     = push_rd;
                sp_dec = push_go;
                if (push_go) state_d = ST_S3;
            end
            ST_S3: begin
                addr   = {8'h01, sp};
                dout   = pc[7:0];
                rw     = push_rd;
                sp_dec = push_go;
                if (push_go) state_d = ST_S4;
            end
            ST_S4: begin
                addr   = {8'h01, sp};
                dout   = {p[7:6], 1'b1, (kind_q == K_BRK), p[3:0]};
                rw     = push_rd;
                sp_dec = push_go;
                if (push_go) state_d = ST_S5;
                if (nmi_lat_q && (kind_q == K_IRQ || kind_q == K_BRK)) kind_d = K_NMI;
            end
            ST_S5: begin
                addr = vec_addr;
                if (READY) begin
                    vec_lo_d = din;
                    state_d  = ST_S6;
                    if (kind_q == K_NMI) nmi_lat_d = 1'b0;
                end
            end
            ST_S6: begin
                addr   = vec_addr + 16'd1;
                pc_new = {din, vec_lo_q};
                if (READY) begin
                    pc_load = 1'b1;
                    set_i   = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_S1;
            kind_q     <= K_RST;
            nmi_lat_q  <= 1'b0;
            nmi_prev_q <= 1'b1;
            first_q    <= 1'b1;
            vec_lo_q   <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            nmi_lat_q  <= nmi_lat_d;
            nmi_prev_q <= nmi_prev_d;
            first_q    <= first_d;
            vec_lo_q   <= vec_lo_d;
        end
    end

endmodule

// File: doc/int_seq.md
Name: int_seq

Overview:
- Interrupt/BRK/reset entry sequencer for the 6502 core, sitting directly upstream of the control block.
- Detects NMI edges and IRQ levels and arbitrates them at instruction boundaries, using `SYNC` from control.
- Once an entry is taken, it owns the external bus for six cycles: it pushes PC and P, fetches the vector, and loads PC.
- Control resumes with a T0 opcode fetch when `done` pulses.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector low-byte address (high byte at +1).
- RST_VEC, 16'hFFFC, reset vector low-byte address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  synchronous reset, active-high
- READY  in  1  bus ready; when low, read cycles stall
- NMI  in  1  non-maskable interrupt, active-low, edge-triggered
- IRQ  in  1  interrupt request, active-low, level
- sync  in  1  opcode-fetch cycle indicator (control SYNC)
- brk_start  in  1  one-cycle pulse from control, BRK decoded
- i_flag  in  1  processor I flag
- pc  in  16  PC value to push
- p  in  8  status register to push
- sp  in  8  stack pointer
- din  in  8  external data bus
- busy  out  1  sequencer owns the bus
- addr  out  16  bus address while busy
- dout  out  8  write data
- rw  out  1  1=read, 0=write
- sp_dec  out  1  decrement SP this cycle
- set_i  out  1  set I flag this cycle
- pc_load  out  1  load PC from pc_new this cycle
- pc_new  out  16  vector target
- done  out  1  one-cycle pulse, last sequencer cycle

Behaviour:
- States: IDLE, S1, S2, S3, S4, S5, S6. `busy` = (state != IDLE).
- Entry kind register, one of RST, NMI, IRQ, BRK.
- Reset (i_rst=1):
  - state<=S1, kind<=RST, nmi_lat<=0, nmi_prev<=1, vec_lo<=0.
  - A held-low NMI across reset is not an edge.
  - The sequence runs automatically after reset release.
- NMI detect:
  - Every cycle, nmi_prev<=NMI.
  - Falling edge (nmi_prev=1, NMI=0) sets nmi_lat.
  - nmi_lat clears in the cycle the vector low byte is fetched for kind NMI.
- Entry from IDLE:
  - Occurs only on a cycle with sync=1 and READY=1.
  - Priority: nmi_lat → NMI; else IRQ=0 and i_flag=0 → IRQ.
  - brk_start=1 in IDLE → BRK, regardless of sync. BRK loses to a simultaneous NMI/IRQ entry, which is taken first.
  - Next state S1.
- S1: dummy read at addr=pc, rw=1.
- S2: push PCH.
  - addr={8'h01,sp}, dout=pc[15:8], sp_dec=1.
  - rw=0, except rw=1 for kind RST.
- S3: push PCL, with the same addr/sp_dec/rw rules as S2; dout=pc[7:0].
- S4: push P.
  - dout = p with bit5=1 and bit4=(kind==BRK).
  - Same addr/sp_dec/rw rules as S2.
- NMI hijack: if nmi_lat is set at S4 with kind IRQ or BRK, kind<=NMI. The BRK pushed B bit stays as already driven.
- S5: read vector low.
  - addr = vector(kind), rw=1; vec_lo<=din.
- S6: read vector high.
  - addr = vector(kind)+1, rw=1.
  - pc_new={din,vec_lo}, pc_load=1, set_i=1, done=1.
  - Next state IDLE.
- READY low:
  - In read states (S1, S5, S6, and S2–S4 when kind=RST), the state holds.
  - No sp_dec, pc_load, done, or vec_lo capture occurs while READY is low.
  - Write states advance regardless of READY.
- Idle outputs: rw=1, addr=0, dout=0, and all pulses 0.
- Latency: entry decision at the sync cycle; PC loaded 6 cycles later if READY=1 throughout.
- IRQ deasserted after entry does not abort the sequence.
- i_rst mid-sequence restarts at S1 with kind RST, discarding any in-flight entry.

Test Plan:
- Reset release, bus returns 34 at FFFC and 12 at FFFD, sp=FD → three cycles with rw=1 and sp_dec pulses; pc_new=1234 with pc_load/set_i/done in cycle 6; no writes.
- IRQ=0, i_flag=0, sync=1, pc=C003, sp=FF, p=20 → writes C0@01FF, 03@01FE (sp input decremented externally), 20@01FD (B=0); vector read from FFFE/FFFF.
- brk_start with p=00 → pushed P=30; vector FFFE; with IRQ=0 and i_flag=1, no IRQ entry occurs afterwards.
- NMI falls during S3 of an IRQ entry → vector switches to FFFA/FFFB; nmi_lat clears; no second NMI entry follows.
- NMI held low through reset, then kept low → no NMI entry; a subsequent high→low edge is taken at the next sync.
- READY=0 for 3 cycles during S5 → state holds; vec_lo is captured only when READY=1; done is delayed by 3 cycles; writes before it are unaffected.
